// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute and the dcache port.
// It computes the effective address, checks alignment, issues the dcache request and extends the load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_base,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_sdata,
  input  logic [4:0]  req_rd,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  output logic        resp_valid,
  output logic        resp_wen,
  output logic [4:0]  resp_waddr,
  output logic [31:0] resp_wdata,
  output logic        resp_ale,
  output logic [31:0] resp_badv
);

  // state | meaning
  // IDLE  | ready for a new op
  // REQ   | dcache request held until dc_req_ready
  // WAIT  | load issued, waiting for dc_rvalid
  // DRAIN | flushed load, swallow its dc_rvalid
  // RESP  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, RESP} state_t;

  localparam logic [2:0] OP_LDB  = 3'd0;
  localparam logic [2:0] OP_LDH  = 3'd1;
  localparam logic [2:0] OP_LDW  = 3'd2;
  localparam logic [2:0] OP_LDBU = 3'd3;
  localparam logic [2:0] OP_LDHU = 3'd4;
  localparam logic [2:0] OP_STB  = 3'd5;
  localparam logic [2:0] OP_STH  = 3'd6;
  localparam logic [2:0] OP_STW  = 3'd7;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [1:0]  addr_lo;
  logic        resp_valid_q;

  logic [31:0] acc_addr;
  logic        acc_store;
  logic        acc_misaligned;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata;
  logic [31:0] rd_shifted;
  logic [31:0] load_value;

  assign req_ready  = (state == IDLE) && !flush;
  assign resp_valid = resp_valid_q && !flush;
  assign acc_addr   = req_base + req_imm;
  assign acc_store  = (req_op == OP_STB) || (req_op == OP_STH) || (req_op == OP_STW);
  assign rd_shifted = dc_rdata >> {addr_lo, 3'b000};

  always_comb begin
    acc_misaligned = 1'b0;
    acc_wstrb      = 4'b0000;
    acc_wdata      = req_sdata;
    case (req_op)
      OP_LDH, OP_LDHU: acc_misaligned = acc_addr[0];
      OP_LDW:          acc_misaligned = |acc_addr[1:0];
      OP_STB: begin
        acc_wstrb = 4'b0001 << acc_addr[1:0];
        acc_wdata = {4{req_sdata[7:0]}};
      end
      OP_STH: begin
        acc_misaligned = acc_addr[0];
        acc_wstrb      = acc_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata      = {2{req_sdata[15:0]}};
      end
      OP_STW: begin
        acc_misaligned = |acc_addr[1:0];
        acc_wstrb      = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_value = rd_shifted;
    case (op_q)
      OP_LDB:  load_value = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      OP_LDH:  load_value = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      OP_LDBU: load_value = {24'd0, rd_shifted[7:0]};
      OP_LDHU: load_value = {16'd0, rd_shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= 3'd0;
      rd_q         <= 5'd0;
      addr_lo      <= 2'd0;
      dc_req_valid <= 1'b0;
      dc_we        <= 1'b0;
      dc_addr      <= 32'd0;
      dc_wstrb     <= 4'd0;
      dc_wdata     <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_wen     <= 1'b0;
      resp_waddr   <= 5'd0;
      resp_wdata   <= 32'd0;
      resp_ale     <= 1'b0;
      resp_badv    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q    <= req_op;
            rd_q    <= req_rd;
            addr_lo <= acc_addr[1:0];
            if (acc_misaligned) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_wen     <= 1'b0;
              resp_ale     <= 1'b1;
              resp_badv    <= acc_addr;
              resp_waddr   <= req_rd;
            end else begin
              state        <= REQ;
              dc_req_valid <= 1'b1;
              dc_we        <= acc_store;
              dc_addr      <= acc_addr;
              dc_wstrb     <= acc_wstrb;
              dc_wdata     <= acc_wdata;
            end
          end
        end
        REQ: begin
          if (dc_req_ready) begin
            dc_req_valid <= 1'b0;
            if (dc_we) begin
              if (flush) begin
                state <= IDLE;
              end else begin
                state        <= RESP;
                resp_valid_q <= 1'b1;
                resp_wen     <= 1'b0;
                resp_ale     <= 1'b0;
                resp_waddr   <= rd_q;
              end
            end else begin
              state <= flush ? DRAIN : WAIT;
            end
          end else if (flush) begin
            dc_req_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        WAIT: begin
          if (dc_rvalid) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_wdata   <= load_value;
              resp_wen     <= (rd_q != 5'd0);
              resp_ale     <= 1'b0;
              resp_waddr   <= rd_q;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dc_rvalid) state <= IDLE;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_wen     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: an arithmetic reference model plus a per-cycle compare process.
module tb_mem_access_ctrl;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_base = 32'd0, req_imm = 32'd0, req_sdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        dc_req_ready = 1'b0, dc_rvalid = 1'b0;
  logic [31:0] dc_rdata = 32'd0;
  logic        req_ready, dc_req_valid, dc_we, resp_valid, resp_wen, resp_ale;
  logic [31:0] dc_addr, dc_wdata, resp_wdata, resp_badv;
  logic [3:0]  dc_wstrb;
  logic [4:0]  resp_waddr;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_base(req_base), .req_imm(req_imm), .req_sdata(req_sdata), .req_rd(req_rd),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_waddr(resp_waddr), .resp_wdata(resp_wdata),
    .resp_ale(resp_ale), .resp_badv(resp_badv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: what one op must produce, from sizes and byte offsets.
  function automatic void model(input logic [2:0] op, input logic [31:0] base, imm, sdata, rdata,
                                input logic [4:0] rd, output logic [31:0] addr, output logic ale,
                                output logic we, output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] res, output logic wen);
    int size, ofs;
    longint v;
    addr = base + imm;
    size = (op == 3'd0 || op == 3'd3 || op == 3'd5) ? 1 : (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 2 : 4;
    we   = (op >= 3'd5);
    ale  = (addr % size) != 0;
    ofs  = int'(addr % 4);
    strb = we ? 4'(((1 << size) - 1) << ofs) : 4'b0000;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sdata[8*(i % size) +: 8];
    v = longint'(rdata >> (8 * ofs));
    v = v % (longint'(1) << (8 * size));
    if ((op == 3'd0 || op == 3'd1) && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    res = v[31:0];
    wen = !we && !ale && (rd != 5'd0);
  endfunction

  logic [31:0] e_addr, e_wd, e_res;
  logic [3:0]  e_strb;
  logic        e_we, e_ale, e_wen;
  logic [4:0]  e_rd;
  int          dc_lo = 1, dc_hi = 0, exp_resp_cyc = -1, acc_cyc = 0;
  bit          active = 0, cmp_dv, cmp_rv;
  logic [31:0] last_wdata, last_dc_addr, last_dc_wdata, last_badv;
  logic [3:0]  last_strb;
  logic        last_wen, last_ale;
  int          last_resp_cyc = -1;

  always @(posedge clk) begin
    #2;
    if (active) begin
      cmp_dv = (cyc >= dc_lo) && (cyc <= dc_hi);
      chk("dc_req_valid", dc_req_valid, cmp_dv);
      if (cmp_dv && dc_req_valid) begin
        chk("dc_addr", dc_addr, e_addr);
        chk("dc_we", dc_we, e_we);
        chk("dc_wstrb", dc_wstrb, e_strb);
        if (e_we) chk("dc_wdata", dc_wdata, e_wd);
        last_dc_addr = dc_addr; last_strb = dc_wstrb; last_dc_wdata = dc_wdata;
      end
      cmp_rv = (cyc == exp_resp_cyc);
      chk("resp_valid", resp_valid, cmp_rv);
      if (cmp_rv && resp_valid) begin
        chk("resp_wen", resp_wen, e_wen);
        chk("resp_ale", resp_ale, e_ale);
        if (e_ale) chk("resp_badv", resp_badv, e_addr);
        if (e_wen) begin
          chk("resp_waddr", resp_waddr, e_rd);
          chk("resp_wdata", resp_wdata, e_res);
        end
        last_wdata = resp_wdata; last_wen = resp_wen; last_ale = resp_ale;
        last_badv = resp_badv; last_resp_cyc = cyc;
      end
    end
  end

  task automatic present(input logic [2:0] op, input logic [31:0] base, imm, sdata, rdata,
                         input logic [4:0] rd);
    model(op, base, imm, sdata, rdata, rd, e_addr, e_ale, e_we, e_strb, e_wd, e_res, e_wen);
    e_rd = rd;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_base = base; req_imm = imm; req_sdata = sdata; req_rd = rd;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    acc_cyc = cyc;
    last_resp_cyc = -1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] base, imm, sdata,
                       input logic [4:0] rd, input int stalls, input int rdelay, input logic [31:0] rdata);
    present(op, base, imm, sdata, rdata, rd);
    if (e_ale) begin
      dc_lo = 1; dc_hi = 0; exp_resp_cyc = acc_cyc + 1;
    end else begin
      dc_lo = acc_cyc + 1; dc_hi = acc_cyc + 1 + stalls;
      exp_resp_cyc = acc_cyc + (e_we ? 2 + stalls : 3 + stalls + rdelay);
    end
    dc_rdata = ~rdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (!e_ale) begin
      repeat (stalls) @(negedge clk);
      dc_req_ready = 1'b1;
      @(negedge clk);
      dc_req_ready = 1'b0;
      if (!e_we) begin
        repeat (rdelay) @(negedge clk);
        dc_rvalid = 1'b1; dc_rdata = rdata;
        @(negedge clk);
        dc_rvalid = 1'b0; dc_rdata = ~rdata;
      end
    end
    req_valid = 1'b1;
    #1 chk("req_ready_in_resp", req_ready, 1'b0);
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_dc_req_valid", dc_req_valid, 1'b0);
    chk("rst_dc_we", dc_we, 1'b0);
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_dc_wstrb", dc_wstrb, 4'd0);
    chk("rst_dc_wdata", dc_wdata, 32'd0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_wen", resp_wen, 1'b0);
    chk("rst_resp_waddr", resp_waddr, 5'd0);
    chk("rst_resp_wdata", resp_wdata, 32'd0);
    chk("rst_resp_ale", resp_ale, 1'b0);
    chk("rst_resp_badv", resp_badv, 32'd0);
    active = 1;

    do_op(3'd0, 32'h1000, 32'h3, 32'h0, 5'd5, 0, 0, 32'h80FF_FF00);
    chk("ldb_lit_wdata", last_wdata, 32'hFFFF_FF80);
    chk("ldb_lit_addr", last_dc_addr, 32'h1003);
    chk("ldb_lit_strb", last_strb, 4'b0000);
    chk("ldb_lit_wen", last_wen, 1'b1);
    chk("ldb_latency", last_resp_cyc - acc_cyc, 3);

    do_op(3'd3, 32'h1000, 32'h3, 32'h0, 5'd5, 0, 0, 32'h80FF_FF00);
    chk("ldbu_lit_wdata", last_wdata, 32'h0000_0080);

    do_op(3'd6, 32'h2000, 32'h2, 32'h1234_ABCD, 5'd9, 2, 0, 32'h0);
    chk("sth_lit_strb", last_strb, 4'b1100);
    chk("sth_lit_wdata", last_dc_wdata, 32'hABCD_ABCD);
    chk("sth_lit_addr", last_dc_addr, 32'h2002);
    chk("sth_latency", last_resp_cyc - acc_cyc, 4);
    chk("sth_lit_wen", last_wen, 1'b0);

    do_op(3'd2, 32'h3000, 32'h2, 32'h0, 5'd4, 0, 0, 32'h0);
    chk("ldw_ale_lit", last_ale, 1'b1);
    chk("ldw_ale_badv", last_badv, 32'h3002);
    chk("ldw_ale_latency", last_resp_cyc - acc_cyc, 1);

    do_op(3'd6, 32'h3000, 32'h1, 32'h5555_6666, 5'd0, 0, 0, 32'h0);
    chk("sth_ale_badv", last_badv, 32'h3001);
    chk("sth_ale_latency", last_resp_cyc - acc_cyc, 1);

    do_op(3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd2, 0, 0, 32'h0000_007F);
    chk("wrap_lit_addr", last_dc_addr, 32'h0);
    chk("wrap_lit_wdata", last_wdata, 32'h0000_007F);

    do_op(3'd2, 32'h4000, 32'h0, 32'h0, 5'd0, 0, 1, 32'hDEAD_BEEF);
    chk("ldw_rd0_wen", last_wen, 1'b0);
    chk("ldw_rd0_latency", last_resp_cyc - acc_cyc, 4);

    do_op(3'd1, 32'h5000, 32'h2, 32'h0, 5'd7, 1, 2, 32'h8001_1234);
    chk("ldh_lit_wdata", last_wdata, 32'hFFFF_8001);
    do_op(3'd4, 32'h5000, 32'h2, 32'h0, 5'd7, 0, 0, 32'h8001_1234);
    chk("ldhu_lit_wdata", last_wdata, 32'h0000_8001);
    do_op(3'd3, 32'h5000, 32'h1, 32'h0, 5'd31, 0, 0, 32'h0000_9A00);
    do_op(3'd5, 32'h6000, 32'h3, 32'h0000_00EF, 5'd1, 0, 0, 32'h0);
    chk("stb_lit_strb", last_strb, 4'b1000);
    chk("stb_lit_wdata", last_dc_wdata, 32'hEFEF_EFEF);
    do_op(3'd7, 32'h6100, 32'hFFFF_FFFC, 32'hCAFE_F00D, 5'd1, 3, 0, 32'h0);
    do_op(3'd2, 32'h6200, 32'h8, 32'h0, 5'd12, 0, 0, 32'h0BAD_F00D);

    // Flushed load in WAIT: its late data must be swallowed.
    present(3'd2, 32'h7000, 32'h0, 32'h0, 32'h1111_2222, 5'd3);
    dc_lo = acc_cyc + 1; dc_hi = acc_cyc + 1; exp_resp_cyc = -1;
    @(negedge clk); req_valid = 1'b0; dc_req_ready = 1'b1;
    @(negedge clk); dc_req_ready = 1'b0; flush = 1'b1;
    #1 chk("flush_wait_ready", req_ready, 1'b0);
    @(negedge clk); flush = 1'b0;
    #1 chk("drain_ready", req_ready, 1'b0);
    @(negedge clk);
    #1 chk("drain_ready_hold", req_ready, 1'b0);
    dc_rvalid = 1'b1; dc_rdata = 32'h1111_2222;
    @(negedge clk); dc_rvalid = 1'b0;
    #1 chk("after_drain_ready", req_ready, 1'b1);
    flush = 1'b1;
    #1 chk("flush_idle_ready", req_ready, 1'b0);
    flush = 1'b0;

    // Flushed store in REQ without handshake: dropped, no response.
    present(3'd7, 32'h8000, 32'h4, 32'hCAFE_F00D, 32'h0, 5'd0);
    dc_lo = acc_cyc + 1; dc_hi = acc_cyc + 1; exp_resp_cyc = -1;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk("req_flush_ready", req_ready, 1'b1);

    // Reset in REQ, then a stray dc_rvalid in IDLE.
    present(3'd2, 32'h9000, 32'h0, 32'h0, 32'h0, 5'd6);
    dc_lo = acc_cyc + 1; dc_hi = acc_cyc + 1; exp_resp_cyc = -1;
    @(negedge clk); req_valid = 1'b0; rst = 1'b1; active = 0;
    @(negedge clk); rst = 1'b0; dc_lo = 1; dc_hi = 0; active = 1;
    @(negedge clk); dc_rvalid = 1'b1; dc_rdata = 32'hFFFF_FFFF;
    #1 chk("stray_rvalid_ready", req_ready, 1'b1);
    @(negedge clk); dc_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    do_op(3'd0, 32'h9000, 32'h2, 32'h0, 5'd8, 0, 0, 32'h00C3_0000);
    chk("post_reset_ldb", last_wdata, 32'hFFFF_FFC3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
